// File: rtl/riscv_dmem_responder.sv
// Data-memory responder for the RISCVunicycle load/store port: one request at a time,
// WAIT_CYCLES wait states, RV32I byte/half/word loads and byte-enabled stores.
module riscv_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [2:0]  cap_funct3;
    logic [31:0] cap_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic        op_we;
    logic [31:0] op_addr;
    logic [2:0]  op_funct3;
    logic [31:0] op_wdata;
    logic [AW-1:0] word_idx;
    logic [31:0] rd_word;
    logic [31:0] shifted;
    logic [3:0]  op_be;
    logic [3:0]  wr_be;
    logic [31:0] wr_word;
    logic [31:0] op_rdata;
    logic        op_err;
    logic        fire;
    logic        wait_done;
    logic        commit;

    // With no wait states the access executes at the accept edge, so it works on the live request.
    assign op_we     = (WAIT_CYCLES == 0) ? req_we     : cap_we;
    assign op_addr   = (WAIT_CYCLES == 0) ? req_addr   : cap_addr;
    assign op_funct3 = (WAIT_CYCLES == 0) ? req_funct3 : cap_funct3;
    assign op_wdata  = (WAIT_CYCLES == 0) ? req_wdata  : cap_wdata;

    assign fire      = (state == S_IDLE) && req_valid && req_ready;
    assign wait_done = (state == S_WAIT) && (cnt == 4'(WAIT_CYCLES));
    assign commit    = rst && ((fire && (WAIT_CYCLES == 0)) || wait_done);

    always_comb begin
        word_idx = op_addr[AW+1:2];
        rd_word  = mem[word_idx];
        shifted  = rd_word >> {op_addr[1:0], 3'b000};
        op_err   = 1'b0;
        op_rdata = '0;
        op_be    = '0;
        if ({2'b00, op_addr[31:2]} >= 32'(DEPTH_WORDS)) op_err = 1'b1;
        if (op_we) begin
            case (op_funct3)
                3'd0: op_be = 4'b0001;
                3'd1: begin op_be = 4'b0011; if (op_addr[0]) op_err = 1'b1; end
                3'd2: begin op_be = 4'b1111; if (op_addr[1:0] != 2'b00) op_err = 1'b1; end
                default: op_err = 1'b1;
            endcase
        end else begin
            case (op_funct3)
                3'd0: op_rdata = {{24{shifted[7]}}, shifted[7:0]};
                3'd4: op_rdata = {24'd0, shifted[7:0]};
                3'd1: begin
                    op_rdata = {{16{shifted[15]}}, shifted[15:0]};
                    if (op_addr[0]) op_err = 1'b1;
                end
                3'd5: begin
                    op_rdata = {16'd0, shifted[15:0]};
                    if (op_addr[0]) op_err = 1'b1;
                end
                3'd2: begin
                    op_rdata = rd_word;
                    if (op_addr[1:0] != 2'b00) op_err = 1'b1;
                end
                default: op_err = 1'b1;
            endcase
        end
        if (op_err) op_rdata = '0;
        wr_be   = op_be << op_addr[1:0];
        wr_word = op_wdata << {op_addr[1:0], 3'b000};
    end

    // Array is deliberately outside the reset domain; contents survive rst.
    always_ff @(posedge clock) begin
        if (commit && op_we && !op_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cap_we     <= 1'b0;
            cap_addr   <= '0;
            cap_funct3 <= '0;
            cap_wdata  <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fire) begin
                        cap_we     <= req_we;
                        cap_addr   <= req_addr;
                        cap_funct3 <= req_funct3;
                        cap_wdata  <= req_wdata;
                        req_ready  <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= op_rdata;
                            rsp_err   <= op_err;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= 4'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_done) begin
                        state     <= S_RESP;
                        cnt       <= '0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= op_rdata;
                        rsp_err   <= op_err;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Directed bench for riscv_dmem_responder: one instance with two wait states and one with none,
// sharing the request inputs.
module tb_riscv_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;

    logic        ready2, valid2, err2;
    logic [31:0] rdata2;
    logic        ready0, valid0, err0;
    logic [31:0] rdata0;

    logic        use0 = 1'b0;
    logic        m_ready, m_valid, m_err;
    logic [31:0] m_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    riscv_dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
        .clock(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready2),
        .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(valid2), .rsp_rdata(rdata2), .rsp_err(err2)
    );

    riscv_dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clock(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready0),
        .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(valid0), .rsp_rdata(rdata0), .rsp_err(err0)
    );

    assign m_ready = use0 ? ready0 : ready2;
    assign m_valid = use0 ? valid0 : valid2;
    assign m_err   = use0 ? err0   : err2;
    assign m_rdata = use0 ? rdata0 : rdata2;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one request, waits for its response and checks latency, ready-low span and the pulse shape.
    task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] wdata, input int wait_cycles,
                          output logic [31:0] rd, output logic er);
        int lat;
        int lowcnt;
        check({name, " ready_before"}, 32'(m_ready), 32'd1);
        req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we = ~we; req_addr = $urandom; req_funct3 = 3'($urandom); req_wdata = $urandom;
        lowcnt = m_ready ? 0 : 1;
        lat = 0;
        while (!m_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (!m_ready) lowcnt++;
        end
        rd = m_rdata;
        er = m_err;
        check({name, " latency"}, 32'(lat), 32'(wait_cycles));
        check({name, " ready_low_cycles"}, 32'(lowcnt), 32'(wait_cycles + 1));
        @(posedge clk); #1;
        check({name, " valid_one_cycle"}, 32'(m_valid), 32'd0);
        check({name, " ready_after"}, 32'(m_ready), 32'd1);
        check({name, " rdata_hold"}, m_rdata, rd);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;

        vecs[0]  = '{"SW 10",   1'b1, 32'h10,  3'd2, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{"LW 10",   1'b0, 32'h10,  3'd2, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{"LB 13",   1'b0, 32'h13,  3'd0, 32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[3]  = '{"LBU 13",  1'b0, 32'h13,  3'd4, 32'h0,        32'h000000DE, 1'b0};
        vecs[4]  = '{"LH 12",   1'b0, 32'h12,  3'd1, 32'h0,        32'hFFFFDEAD, 1'b0};
        vecs[5]  = '{"LHU 10",  1'b0, 32'h10,  3'd5, 32'h0,        32'h0000BEEF, 1'b0};
        vecs[6]  = '{"SB 11",   1'b1, 32'h11,  3'd0, 32'hFFFFFF55, 32'h0,        1'b0};
        vecs[7]  = '{"LW 10b",  1'b0, 32'h10,  3'd2, 32'h0,        32'hDEAD55EF, 1'b0};
        vecs[8]  = '{"SH 12",   1'b1, 32'h12,  3'd1, 32'hABCD1234, 32'h0,        1'b0};
        vecs[9]  = '{"LW 10c",  1'b0, 32'h10,  3'd2, 32'h0,        32'h123455EF, 1'b0};
        vecs[10] = '{"LW 11",   1'b0, 32'h11,  3'd2, 32'h0,        32'h0,        1'b1};
        vecs[11] = '{"SH 13",   1'b1, 32'h13,  3'd1, 32'h0000FFFF, 32'h0,        1'b1};
        vecs[12] = '{"LW 400",  1'b0, 32'h400, 3'd2, 32'h0,        32'h0,        1'b1};
        vecs[13] = '{"LD f3=3", 1'b0, 32'h10,  3'd3, 32'h0,        32'h0,        1'b1};
        vecs[14] = '{"ST f3=3", 1'b1, 32'h10,  3'd3, 32'h0,        32'h0,        1'b1};
        vecs[15] = '{"LW 10d",  1'b0, 32'h10,  3'd2, 32'h0,        32'h123455EF, 1'b0};
        vecs[16] = '{"LB 11",   1'b0, 32'h11,  3'd0, 32'h0,        32'h00000055, 1'b0};
        vecs[17] = '{"LH 10",   1'b0, 32'h10,  3'd1, 32'h0,        32'h000055EF, 1'b0};
        vecs[18] = '{"SW 3FC",  1'b1, 32'h3FC, 3'd2, 32'h80000001, 32'h0,        1'b0};
        vecs[19] = '{"LW 3FC",  1'b0, 32'h3FC, 3'd2, 32'h0,        32'h80000001, 1'b0};
        vecs[20] = '{"LHU 3FE", 1'b0, 32'h3FE, 3'd5, 32'h0,        32'h00008000, 1'b0};
        vecs[21] = '{"LB 3FF",  1'b0, 32'h3FF, 3'd0, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[22] = '{"SW 20",   1'b1, 32'h20,  3'd2, 32'h00000000, 32'h0,        1'b0};
        vecs[23] = '{"LW 10e",  1'b0, 32'h10,  3'd2, 32'h0,        32'h123455EF, 1'b0};

        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_funct3 = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 32'(ready2), 32'd1);
        check("reset valid", 32'(valid2), 32'd0);
        check("reset rdata", rdata2, 32'h0);
        check("reset err", 32'(err2), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            do_req(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wdata, 2, rd, er);
            check({vecs[i].name, " rdata"}, rd, vecs[i].exp_rdata);
            check({vecs[i].name, " err"}, 32'(er), 32'(vecs[i].exp_err));
        end

        // Reset while SW 0x20 sits in WAIT: store dropped, outputs cleared at once, requests ignored.
        req_we = 1'b1; req_addr = 32'h20; req_funct3 = 3'd2; req_wdata = 32'hA5A5A5A5;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_wait ready", 32'(ready2), 32'd1);
        check("rst_wait valid", 32'(valid2), 32'd0);
        check("rst_wait rdata", rdata2, 32'h0);
        check("rst_wait err", 32'(err2), 32'd0);
        req_we = 1'b1; req_addr = 32'h20; req_funct3 = 3'd2; req_wdata = 32'hFFFFFFFF;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_hold valid", 32'(valid2), 32'd0);
            check("rst_hold ready", 32'(ready2), 32'd1);
        end
        req_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rst_release valid", 32'(valid2), 32'd0);
        do_req("LW 20", 1'b0, 32'h20, 3'd2, 32'h0, 2, rd, er);
        check("LW 20 rdata", rd, 32'h0);
        check("LW 20 err", 32'(er), 32'd0);

        // Zero wait states.
        use0 = 1'b1;
        #1;
        do_req("W0 SW 40", 1'b1, 32'h40, 3'd2, 32'h0BADF00D, 0, rd, er);
        check("W0 SW 40 err", 32'(er), 32'd0);
        do_req("W0 LW 40", 1'b0, 32'h40, 3'd2, 32'h0, 0, rd, er);
        check("W0 LW 40 rdata", rd, 32'h0BADF00D);
        check("W0 LW 40 err", 32'(er), 32'd0);

        // req_valid held high: accepts land exactly two cycles apart.
        req_we = 1'b0; req_addr = 32'h42; req_funct3 = 3'd5; req_wdata = '0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        check("W0 held acc1 valid", 32'(valid0), 32'd1);
        check("W0 held acc1 ready", 32'(ready0), 32'd0);
        check("W0 held acc1 rdata", rdata0, 32'h00000BAD);
        @(posedge clk); #1;
        check("W0 held gap valid", 32'(valid0), 32'd0);
        check("W0 held gap ready", 32'(ready0), 32'd1);
        req_addr = 32'h40; req_funct3 = 3'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("W0 held acc2 valid", 32'(valid0), 32'd1);
        check("W0 held acc2 rdata", rdata0, 32'h0000000D);
        @(posedge clk); #1;
        check("W0 held end valid", 32'(valid0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_dmem_responder.md
# riscv_dmem_responder

Data-memory responder for the RISCVunicycle core's load/store port. It accepts one request at a time from the core over a valid/ready handshake and holds it for a programmable number of wait states. It then performs RV32I byte/half/word reads with sign/zero extension, or byte-enabled writes, against an internal word array. Misaligned, out-of-range and illegal-width accesses are reported on an error flag instead of being executed.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words in the array; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2: wait states between accept and response; legal range 0..15.

- clock  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_funct3  in  3  RV32I width code. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load result; 0 for stores and for errors.
- rsp_err  out  1  qualifies rsp_valid; request was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE → WAIT on req_valid && req_ready when WAIT_CYCLES > 0.
  - IDLE → RESP on the same condition when WAIT_CYCLES = 0.
  - WAIT → RESP when the wait counter reaches WAIT_CYCLES.
  - RESP → IDLE unconditionally.
- At the accept edge, we, addr, funct3 and wdata are captured into registers. Request inputs are don't-care after acceptance.
- Error check on captured fields; any one of these sets the error:
  - LH/LHU/SH with addr[0] = 1.
  - LW/SW with addr[1:0] ≠ 0.
  - addr[31:2] ≥ DEPTH_WORDS.
  - Load funct3 of 3, 6 or 7.
  - Store funct3 > 2.
- Load, no error: the selected byte or half is taken from word addr[31:2] at lane addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.
- Store, no error: only the addressed lanes are written (SB 1 lane, SH 2, SW 4); other lanes are unchanged.
- On error: no array write, rsp_rdata = 0, rsp_err = 1.
- No response backpressure. The core must sample the response in the rsp_valid cycle.
- Array contents are not cleared by reset and are undefined until written.

## Timing
- Reset values (asserted asynchronously while rst = 0):
  - state = IDLE, wait counter = 0.
  - req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Requests are ignored while rst = 0.
- Accept at edge E0. The array write/read and the RESP entry happen at edge E0 + WAIT_CYCLES. rsp_valid is high for exactly the following cycle.
- req_ready is low from E0 until the cycle after RESP. Minimum request spacing is WAIT_CYCLES + 2 cycles.
- rsp_rdata and rsp_err update only at the RESP-entry edge and hold until the next response.
- A read reflects all earlier committed writes. Back-to-back store then load to the same address returns the stored data.
- Reset during WAIT: the captured request is dropped and nothing is written.
- Reset during RESP: rsp_valid drops immediately. The write committed at RESP entry is retained.
- req_valid held high while in WAIT/RESP is not accepted. It is accepted on the first IDLE cycle.

## Test plan
- WAIT_CYCLES=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → rsp_valid exactly 2 cycles after each accept edge, rdata 0xDEADBEEF, err 0; req_ready low for 3 cycles per request.
- After that word: LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- SB 0x11 data 0x55, then LW 0x10 → 0xDEAD55EF; SH 0x12 data 0x1234, then LW 0x10 → 0x123455EF.
- Errors: LW 0x11, SH 0x13, LW 4*DEPTH_WORDS, load funct3=3 → each gives err 1, rdata 0. A following LW 0x10 still returns 0x123455EF.
- WAIT_CYCLES=0: LW accepted at E0 → rsp_valid in the cycle after E0; next accept no earlier than E0+2.
- Pulse rst low one cycle after accepting SW 0x20 data 0xA5A5A5A5 (WAIT_CYCLES=2) → outputs go to reset values at once, no response is issued, and LW 0x20 after a prior known write of 0 returns 0.
